graph_trace_mixer: RTL and testbench

//  Pipelined, parametrised colour mixer for the multi-trace sensor graph on the VGA panel.
//  - Takes a per-pixel one-hot-per-channel trace code from the graph renderer.
//  - Sums the programmable palette colours of all hit channels, saturating each component.
//  - Emits RGB to the pixel output mux after a fixed 2-cycle latency.
//  - Replaces fixed-colour combinational mixing: runtime palette, channel enable mask, optional blink.

---
 rtl/graph_mix_pkg.sv | 59 +++++
 rtl/graph_mix_sat_add.sv | 39 +++
 rtl/graph_trace_mixer.sv | 180 ++++++++++++++++++
 tb/tb_graph_trace_mixer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/graph_mix_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : graph_mix_pkg                                                |
// | Description : Shared types and constants for the multi-trace graph colour  |
// |               mixer: default component width, packed RGB type, default     |
// |               trace palette and a helper that scales a default entry to an |
// |               arbitrary component width.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package graph_mix_pkg;

  localparam int CW_DEFAULT = 8;
  localparam int N_DEFAULTS = 6;

  typedef struct packed {
    logic [CW_DEFAULT-1:0] r;
    logic [CW_DEFAULT-1:0] g;
    logic [CW_DEFAULT-1:0] b;
  } rgb_t;

  // Entries 0..4 are the dedicated trace colours; the last entry is the
  // neutral grey used for every channel beyond the fifth.
  localparam rgb_t DEFAULT_PALETTE [N_DEFAULTS] = '{
    rgb_t'(24'hFF0000),
    rgb_t'(24'h00FF00),
    rgb_t'(24'h0000FF),
    rgb_t'(24'hC800C8),
    rgb_t'(24'h96AF00),
    rgb_t'(24'h808080)
  };

  // Returns the default colour of channel idx as {R,G,B} packed in the low
  // 3*cw bits. Each component is MSB-aligned to cw bits (left shift when
  // widening, truncating right shift when narrowing). Valid for cw <= 21.
  function automatic logic [63:0] pal_default(input int idx, input int cw);
    rgb_t                  e;
    logic [2:0]            sel;
    logic [CW_DEFAULT-1:0] comp [3];
    logic [63:0]           s;
    logic [63:0]           res;
    sel     = (idx < N_DEFAULTS - 1) ? 3'(idx) : 3'(N_DEFAULTS - 1);
    e       = DEFAULT_PALETTE[sel];
    comp[0] = e.r;
    comp[1] = e.g;
    comp[2] = e.b;
    res     = '0;
    for (int c = 0; c < 3; c++) begin
      s = 64'(comp[c]);
      if (cw >= CW_DEFAULT) s = s << (cw - CW_DEFAULT);
      else                  s = s >> (CW_DEFAULT - cw);
      res = res | (s << ((2 - c) * cw));
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/graph_mix_sat_add.sv
// +----------------------------------------------------------------------------+
// | Module      : graph_mix_sat_add                                            |
// | Description : N-input masked saturating adder for one colour component.    |
// |               Sums every input whose mask bit is set and clamps the result |
// |               to the largest CW-bit value.                                 |
// | Ports       : i_mask [N_CH]      - per-input enable                        |
// |               i_vals [N_CH*CW]   - inputs, input i at [i*CW +: CW]         |
// |               o_sum  [CW]        - clamped sum (combinational)             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module graph_mix_sat_add #(
  parameter int N_CH = 5,
  parameter int CW   = 8
) (
  input  logic [N_CH-1:0]    i_mask,
  input  logic [N_CH*CW-1:0] i_vals,
  output logic [CW-1:0]      o_sum
);

  // Wide enough that N_CH full-scale inputs never wrap before clamping.
  localparam int c_SUM_W = CW + $clog2(N_CH + 1);

  logic [c_SUM_W-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (i_mask[i]) w_acc = w_acc + c_SUM_W'(i_vals[i*CW +: CW]);
    end
  end

  // Any bit above the component width means the sum exceeded full scale.
  assign o_sum = (|w_acc[c_SUM_W-1:CW]) ? {CW{1'b1}} : w_acc[CW-1:0];

endmodule

`default_nettype wire

// File: rtl/graph_trace_mixer.sv
// +----------------------------------------------------------------------------+
// | Module      : graph_trace_mixer                                            |
// | Description : Two-stage pipelined colour mixer for the multi-trace sensor  |
// |               graph. Each pixel's trace code is masked by the channel      |
// |               enables (and optional blink suppression), then the palette   |
// |               colours of all hit channels are summed with per-component    |
// |               saturation. Fixed 2-clock latency, full throughput.          |
// | Config      : GRAPH_MIX_BLINK_EN - adds blink_mask input and a frame       |
// |               counter that suppresses masked channels on alternate         |
// |               BLINK_FRAMES-frame half-periods.                             |
// | Ports       : clk, rst (async, active high)                                |
// |               pal_we/pal_addr/pal_data - runtime palette write             |
// |               ch_en       - channel enable mask                            |
// |               in_valid/in_px_code/in_sof - pixel stream from renderer      |
// |               blink_mask  - channels that blink (GRAPH_MIX_BLINK_EN only)  |
// |               out_valid/out_R/out_G/out_B/out_hit - mixed pixel            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module graph_trace_mixer
  import graph_mix_pkg::*;
#(
  parameter int N_CH = 5,
  parameter int CW   = CW_DEFAULT
`ifdef GRAPH_MIX_BLINK_EN
  , parameter int BLINK_FRAMES = 30
`endif
  , localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pal_we,
  input  logic [AW-1:0]   pal_addr,
  input  logic [3*CW-1:0] pal_data,
  input  logic [N_CH-1:0] ch_en,
  input  logic            in_valid,
  input  logic [N_CH-1:0] in_px_code,
  input  logic            in_sof,
`ifdef GRAPH_MIX_BLINK_EN
  input  logic [N_CH-1:0] blink_mask,
`endif
  output logic            out_valid,
  output logic [CW-1:0]   out_R,
  output logic [CW-1:0]   out_G,
  output logic [CW-1:0]   out_B,
  output logic            out_hit
);

  function automatic logic [3*CW-1:0] def_entry(input int idx);
    logic [63:0] t;
    t = pal_default(idx, CW);
    return t[3*CW-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Blink suppression
  // --------------------------------------------------------------------------
  logic [N_CH-1:0] w_suppress;

`ifdef GRAPH_MIX_BLINK_EN
  localparam int c_FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [c_FC_W-1:0] r_fc;
  logic              r_blink_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fc          <= '0;
      r_blink_phase <= 1'b0;
    end else if (in_sof) begin
      if (r_fc == c_FC_W'(BLINK_FRAMES - 1)) begin
        r_fc          <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_fc <= r_fc + 1'b1;
      end
    end
  end

  // A pixel arriving with in_sof sees the phase from before that edge.
  assign w_suppress = r_blink_phase ? blink_mask : '0;
`else
  logic w_unused_sof;
  assign w_unused_sof = in_sof;
  assign w_suppress   = '0;
`endif

  // --------------------------------------------------------------------------
  // Palette registers
  // --------------------------------------------------------------------------
  logic [3*CW-1:0] r_pal [N_CH];

  // Addresses >= N_CH match no entry, so such writes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) r_pal[i] <= def_entry(i);
    end else if (pal_we) begin
      for (int i = 0; i < N_CH; i++) begin
        if (pal_addr == AW'(i)) r_pal[i] <= pal_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: capture valid and effective channel hits
  // --------------------------------------------------------------------------
  logic            r_v1;
  logic [N_CH-1:0] r_c1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_c1 <= '0;
    end else begin
      r_v1 <= in_valid;
      r_c1 <= in_px_code & ch_en & ~w_suppress;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: per-component saturating sum over the hit channels
  // --------------------------------------------------------------------------
  logic [N_CH*CW-1:0] w_vals_r;
  logic [N_CH*CW-1:0] w_vals_g;
  logic [N_CH*CW-1:0] w_vals_b;
  logic [CW-1:0]      w_sum_r;
  logic [CW-1:0]      w_sum_g;
  logic [CW-1:0]      w_sum_b;

  for (genvar i = 0; i < N_CH; i++) begin : g_flat
    assign w_vals_r[i*CW +: CW] = r_pal[i][3*CW-1 -: CW];
    assign w_vals_g[i*CW +: CW] = r_pal[i][2*CW-1 -: CW];
    assign w_vals_b[i*CW +: CW] = r_pal[i][CW-1:0];
  end

  graph_mix_sat_add #(.N_CH(N_CH), .CW(CW)) u_add_r (
    .i_mask (r_c1),
    .i_vals (w_vals_r),
    .o_sum  (w_sum_r)
  );

  graph_mix_sat_add #(.N_CH(N_CH), .CW(CW)) u_add_g (
    .i_mask (r_c1),
    .i_vals (w_vals_g),
    .o_sum  (w_sum_g)
  );

  graph_mix_sat_add #(.N_CH(N_CH), .CW(CW)) u_add_b (
    .i_mask (r_c1),
    .i_vals (w_vals_b),
    .o_sum  (w_sum_b)
  );

  // Bubbles are forced to all-zero so the downstream mux never sees stale colour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_R     <= '0;
      out_G     <= '0;
      out_B     <= '0;
      out_hit   <= 1'b0;
    end else if (r_v1) begin
      out_valid <= 1'b1;
      out_R     <= w_sum_r;
      out_G     <= w_sum_g;
      out_B     <= w_sum_b;
      out_hit   <= |r_c1;
    end else begin
      out_valid <= 1'b0;
      out_R     <= '0;
      out_G     <= '0;
      out_B     <= '0;
      out_hit   <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_graph_trace_mixer.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_graph_trace_mixer                                         |
// | Description : Scoreboard testbench for graph_trace_mixer (N_CH=5, CW=8).   |
// |               The driver pushes expected pixels (explicit constants for    |
// |               the directed cases, a palette/sum model for random traffic); |
// |               a monitor pops and compares on every output cycle.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_graph_trace_mixer;

  localparam int N_CH = 5;
  localparam int CW   = 8;
  localparam int AW   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            pal_we;
  logic [AW-1:0]   pal_addr;
  logic [3*CW-1:0] pal_data;
  logic [N_CH-1:0] ch_en;
  logic            in_valid;
  logic [N_CH-1:0] in_px_code;
  logic            in_sof;
`ifdef GRAPH_MIX_BLINK_EN
  logic [N_CH-1:0] blink_mask;
`endif
  logic            out_valid;
  logic [CW-1:0]   out_R;
  logic [CW-1:0]   out_G;
  logic [CW-1:0]   out_B;
  logic            out_hit;

  graph_trace_mixer #(.N_CH(N_CH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
    .ch_en      (ch_en),
    .in_valid   (in_valid),
    .in_px_code (in_px_code),
    .in_sof     (in_sof),
`ifdef GRAPH_MIX_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .out_valid  (out_valid),
    .out_R      (out_R),
    .out_G      (out_G),
    .out_B      (out_B),
    .out_hit    (out_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         stamp;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hit;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [23:0] m_pal [N_CH];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    m_pal[0] = 24'hFF0000;
    m_pal[1] = 24'h00FF00;
    m_pal[2] = 24'h0000FF;
    m_pal[3] = 24'hC800C8;
    m_pal[4] = 24'h96AF00;
  endfunction

  function automatic int clamp(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Expected pixel: sum the palette colours of every drawn channel, clamp each component.
  function automatic exp_t model_px(input logic [4:0] code, input logic [4:0] en, input int stamp);
    exp_t e;
    int   sr = 0, sg = 0, sb = 0;
    logic [4:0] m = code & en;
    for (int i = 0; i < N_CH; i++) begin
      if (m[i]) begin
        sr += int'(m_pal[i][23:16]);
        sg += int'(m_pal[i][15:8]);
        sb += int'(m_pal[i][7:0]);
      end
    end
    e.stamp = stamp;
    e.r     = 8'(clamp(sr));
    e.g     = 8'(clamp(sg));
    e.b     = 8'(clamp(sb));
    e.hit   = (m != 0);
    return e;
  endfunction

  // One input cycle; a palette write lands in the same edge as the pixel's
  // stage 1, so that pixel already sees the new colour.
  task automatic drive(input logic v, input logic [4:0] code, input logic [4:0] en,
                       input logic we, input logic [2:0] addr, input logic [23:0] data);
    @(negedge clk);
    in_valid   = v;
    in_px_code = code;
    ch_en      = en;
    pal_we     = we;
    pal_addr   = addr;
    pal_data   = data;
    if (we && addr < 3'(N_CH)) m_pal[addr] = data;
    if (v) q.push_back(model_px(code, en, cyc + 2));
  endtask

  // Directed pixel with a hand-derived expectation.
  task automatic drive_k(input logic [4:0] code, input logic [4:0] en,
                         input logic [23:0] rgb, input logic hit);
    exp_t e;
    @(negedge clk);
    in_valid   = 1'b1;
    in_px_code = code;
    ch_en      = en;
    pal_we     = 1'b0;
    e.stamp    = cyc + 2;
    e.r        = rgb[23:16];
    e.g        = rgb[15:8];
    e.b        = rgb[7:0];
    e.hit      = hit;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 5'h1F, 1'b0, 3'd0, 24'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    pal_we   = 1'b0;
    q.delete();
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_R !== 8'd0 || out_G !== 8'd0 || out_B !== 8'd0 || out_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b rgb=%h%h%h hit=%b, want all zero",
               out_valid, out_R, out_G, out_B, out_hit);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares every output cycle against the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got rgb=%h%h%h hit=%b at cyc %0d, want no output",
                   out_R, out_G, out_B, out_hit, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (cyc != e.stamp || out_R !== e.r || out_G !== e.g || out_B !== e.b || out_hit !== e.hit) begin
            errors++;
            $display("FAIL pixel: got rgb=%h%h%h hit=%b cyc=%0d, want rgb=%h%h%h hit=%b cyc=%0d",
                     out_R, out_G, out_B, out_hit, cyc, e.r, e.g, e.b, e.hit, e.stamp);
          end
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || out_R !== 8'd0 || out_G !== 8'd0 || out_B !== 8'd0 || out_hit !== 1'b0) begin
          errors++;
          $display("FAIL bubble: got v=%b rgb=%h%h%h hit=%b, want all zero",
                   out_valid, out_R, out_G, out_B, out_hit);
        end
        if (q.size() != 0 && q[0].stamp <= cyc) begin
          exp_t e;
          e = q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_pixel: got no output at cyc %0d, want rgb=%h%h%h",
                   cyc, e.r, e.g, e.b);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    pal_we     = 1'b0;
    pal_addr   = '0;
    pal_data   = '0;
    ch_en      = 5'h1F;
    in_valid   = 1'b0;
    in_px_code = '0;
    in_sof     = 1'b0;
`ifdef GRAPH_MIX_BLINK_EN
    blink_mask = '0;
`endif
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_R !== 8'd0 || out_G !== 8'd0 || out_B !== 8'd0 || out_hit !== 1'b0) begin
      errors++;
      $display("FAIL initial_reset: got v=%b rgb=%h%h%h hit=%b, want all zero",
               out_valid, out_R, out_G, out_B, out_hit);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Default palette mixing and saturation
    drive_k(5'b00011, 5'h1F, 24'hFFFF00, 1'b1);
    drive_k(5'b11000, 5'h1F, 24'hFFAFC8, 1'b1);
    drive_k(5'b00000, 5'h1F, 24'h000000, 1'b0);
    drive_k(5'b11111, 5'h1F, 24'hFFFFFF, 1'b1);
    idle(1);

    // Palette write, then the pixel on the following cycle
    drive(1'b0, 5'd0, 5'h1F, 1'b1, 3'd2, 24'h102030);
    drive_k(5'b00100, 5'h1F, 24'h102030, 1'b1);
    // Out-of-range address must not disturb any entry
    drive(1'b0, 5'd0, 5'h1F, 1'b1, 3'd7, 24'hABCDEF);
    drive_k(5'b00001, 5'h1F, 24'hFF0000, 1'b1);
    drive_k(5'b00010, 5'h1F, 24'h00FF00, 1'b1);
    drive_k(5'b00100, 5'h1F, 24'h102030, 1'b1);
    drive_k(5'b01000, 5'h1F, 24'hC800C8, 1'b1);
    drive_k(5'b10000, 5'h1F, 24'h96AF00, 1'b1);

    // Disabled channel and bubbles
    drive_k(5'b00001, 5'b11110, 24'h000000, 1'b0);
    idle(1);
    drive_k(5'b00010, 5'h1F, 24'h00FF00, 1'b1);
    idle(2);
    drive_k(5'b01000, 5'h1F, 24'hC800C8, 1'b1);

    // Write coinciding with a pixel: the pixel uses the new value, the one before does not
    drive(1'b1, 5'b00001, 5'h1F, 1'b0, 3'd0, 24'd0);
    drive(1'b1, 5'b00001, 5'h1F, 1'b1, 3'd0, 24'h123456);
    drive(1'b1, 5'b00001, 5'h1F, 1'b0, 3'd0, 24'd0);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom), ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1F,
            $urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)), 24'($urandom));
    end

    // Mid-stream reset: in-flight pixels dropped, palette back to defaults
    drive(1'b1, 5'b00100, 5'h1F, 1'b0, 3'd0, 24'd0);
    do_reset();
    drive_k(5'b00100, 5'h1F, 24'h0000FF, 1'b1);
    drive_k(5'b00001, 5'h1F, 24'hFF0000, 1'b1);

    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom), ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1F,
            $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), 24'($urandom));
    end

    idle(4);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pixels outstanding, want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
